// File: rtl/shot_round_ctl.sv
// rtl/shot_round_ctl.sv - click-to-hit sequencer tracking shots, ducks and score per game
`timescale 1ns/1ps
module shot_round_ctl #(
   parameter int DUCK_WIDTH     = 64,
   parameter int DUCK_HEIGHT    = 64,
   parameter int SHOTS_PER_DUCK = 3,
   parameter int DUCKS_PER_GAME = 10,
   parameter int FLASH_CYCLES   = 3250000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        game_enable,
   input  logic        left_mouse,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic [11:0] duck_xpos,
   input  logic [11:0] duck_ypos,
   output logic        duck_respawn,
   output logic        duck_hit,
   output logic [3:0]  shots_left,
   output logic [7:0]  duck_count,
   output logic [7:0]  score,
   output logic        game_finished
);

   typedef enum logic [2:0] {IDLE, ARMED, EVAL, HIT, ESCAPE, DONE} state_t;

   localparam int             FW         = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
   localparam logic [FW-1:0]  FLASH_LAST = FW'(FLASH_CYCLES - 1);
   localparam logic [3:0]     SHOTS_INIT = 4'(SHOTS_PER_DUCK);
   localparam logic [7:0]     DUCKS_LAST = 8'(DUCKS_PER_GAME);

   state_t         state;
   logic           left_mouse_d;
   logic [11:0]    mx, my, dx, dy;
   logic [FW-1:0]  flash_cnt;
   logic           click;
   logic           hit;

   assign click = left_mouse & ~left_mouse_d;

   // 13-bit compares so a duck near the 4095 edge does not wrap its hitbox
   assign hit = ({1'b0, mx} >= {1'b0, dx}) &&
                ({1'b0, mx} <  ({1'b0, dx} + 13'(DUCK_WIDTH))) &&
                ({1'b0, my} >= {1'b0, dy}) &&
                ({1'b0, my} <  ({1'b0, dy} + 13'(DUCK_HEIGHT)));

   // round sequencer: state, counters and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         left_mouse_d  <= 1'b0;
         mx            <= '0;
         my            <= '0;
         dx            <= '0;
         dy            <= '0;
         flash_cnt     <= '0;
         duck_respawn  <= 1'b0;
         duck_hit      <= 1'b0;
         shots_left    <= '0;
         duck_count    <= '0;
         score         <= '0;
         game_finished <= 1'b0;
      end else begin
         left_mouse_d <= left_mouse;
         duck_respawn <= 1'b0;
         if (state != IDLE && !game_enable) begin
            // leaving the game keeps score/duck_count for the end screen
            state         <= IDLE;
            duck_hit      <= 1'b0;
            game_finished <= 1'b0;
            flash_cnt     <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (game_enable) begin
                     score        <= '0;
                     duck_count   <= '0;
                     shots_left   <= SHOTS_INIT;
                     duck_respawn <= 1'b1;
                     state        <= ARMED;
                  end
               end
               ARMED: begin
                  if (click) begin
                     mx    <= mouse_xpos;
                     my    <= mouse_ypos;
                     dx    <= duck_xpos;
                     dy    <= duck_ypos;
                     state <= EVAL;
                  end
               end
               EVAL: begin
                  flash_cnt <= '0;
                  if (hit) begin
                     if (score != 8'hFF)
                        score <= score + 8'd1;
                     duck_hit <= 1'b1;
                     state    <= HIT;
                  end else begin
                     shots_left <= shots_left - 4'd1;
                     state      <= (shots_left == 4'd1) ? ESCAPE : ARMED;
                  end
               end
               HIT, ESCAPE: begin
                  if (flash_cnt == FLASH_LAST) begin
                     flash_cnt  <= '0;
                     duck_hit   <= 1'b0;
                     duck_count <= duck_count + 8'd1;
                     if (duck_count + 8'd1 == DUCKS_LAST) begin
                        game_finished <= 1'b1;
                        state         <= DONE;
                     end else begin
                        shots_left   <= SHOTS_INIT;
                        duck_respawn <= 1'b1;
                        state        <= ARMED;
                     end
                  end else begin
                     flash_cnt <= flash_cnt + FW'(1);
                  end
               end
               DONE: begin
                  game_finished <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shot_round_ctl.sv
// tb/tb_shot_round_ctl.sv - directed-vector bench for shot_round_ctl
`timescale 1ns/1ps
module tb_shot_round_ctl;

   logic        clk;
   logic        rst;
   logic        game_enable;
   logic        left_mouse;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic [11:0] duck_xpos;
   logic [11:0] duck_ypos;
   logic        duck_respawn;
   logic        duck_hit;
   logic [3:0]  shots_left;
   logic [7:0]  duck_count;
   logic [7:0]  score;
   logic        game_finished;

   int vec_cnt = 0;
   int err_cnt = 0;

   shot_round_ctl #(
      .DUCK_WIDTH     (64),
      .DUCK_HEIGHT    (64),
      .SHOTS_PER_DUCK (3),
      .DUCKS_PER_GAME (2),
      .FLASH_CYCLES   (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .game_enable   (game_enable),
      .left_mouse    (left_mouse),
      .mouse_xpos    (mouse_xpos),
      .mouse_ypos    (mouse_ypos),
      .duck_xpos     (duck_xpos),
      .duck_ypos     (duck_ypos),
      .duck_respawn  (duck_respawn),
      .duck_hit      (duck_hit),
      .shots_left    (shots_left),
      .duck_count    (duck_count),
      .score         (score),
      .game_finished (game_finished)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic click(input logic [11:0] x, input logic [11:0] y);
      mouse_xpos = x;
      mouse_ypos = y;
      left_mouse = 1'b1;
      step();
      left_mouse = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; game_enable = 1'b0; left_mouse = 1'b0;
      mouse_xpos = '0; mouse_ypos = '0; duck_xpos = '0; duck_ypos = '0;
      step(); step();
      chk("rst_respawn", duck_respawn, 0);
      chk("rst_hit", duck_hit, 0);
      chk("rst_shots", shots_left, 0);
      chk("rst_count", duck_count, 0);
      chk("rst_score", score, 0);
      chk("rst_finished", game_finished, 0);
      rst = 1'b0;
      step();

      // single hit at the inclusive bottom-right pixel
      duck_xpos = 12'd100; duck_ypos = 12'd100;
      game_enable = 1'b1;
      step();
      chk("start_respawn", duck_respawn, 1);
      chk("start_shots", shots_left, 3);
      step();
      chk("start_respawn_drop", duck_respawn, 0);
      mouse_xpos = 12'd163; mouse_ypos = 12'd163; left_mouse = 1'b1;
      step();
      chk("hit_lat1", duck_hit, 0);
      left_mouse = 1'b0;
      step();
      chk("hit_lat2", duck_hit, 1);
      chk("hit_score", score, 1);
      step(); step(); step();
      chk("hit_flash_hold", duck_hit, 1);
      chk("hit_flash_count", duck_count, 0);
      step();
      chk("hit_end_hit", duck_hit, 0);
      chk("hit_end_count", duck_count, 1);
      chk("hit_end_respawn", duck_respawn, 1);
      chk("hit_end_shots", shots_left, 3);
      step();
      chk("hit_respawn_drop", duck_respawn, 0);

      // exclusive right and bottom edges, then inclusive top-left corner
      click(12'd164, 12'd120);
      chk("edge_right_miss", shots_left, 2);
      click(12'd120, 12'd164);
      chk("edge_bottom_miss", shots_left, 1);
      click(12'd100, 12'd100);
      chk("edge_topleft_hit", duck_hit, 1);
      chk("edge_score", score, 2);
      step(); step(); step(); step();
      chk("done_finished", game_finished, 1);
      chk("done_count", duck_count, 2);
      chk("done_no_respawn", duck_respawn, 0);
      chk("done_hit_low", duck_hit, 0);
      click(12'd100, 12'd100);
      chk("done_click_ignored", score, 2);

      // leave and re-enter the game
      game_enable = 1'b0;
      step();
      chk("exit_finished", game_finished, 0);
      chk("exit_score_held", score, 2);
      chk("exit_count_held", duck_count, 2);
      game_enable = 1'b1;
      step();
      chk("reenter_score", score, 0);
      chk("reenter_count", duck_count, 0);
      chk("reenter_respawn", duck_respawn, 1);
      chk("reenter_shots", shots_left, 3);
      step();

      // escape after three misses
      duck_xpos = 12'd200; duck_ypos = 12'd200;
      click(12'd0, 12'd0);
      chk("esc_shots2", shots_left, 2);
      click(12'd0, 12'd0);
      chk("esc_shots1", shots_left, 1);
      click(12'd0, 12'd0);
      chk("esc_shots0", shots_left, 0);
      chk("esc_hit_low", duck_hit, 0);
      chk("esc_score", score, 0);
      step(); step(); step();
      chk("esc_flash_count", duck_count, 0);
      left_mouse = 1'b1;
      step();
      chk("esc_end_count", duck_count, 1);
      chk("esc_end_shots", shots_left, 3);
      chk("esc_end_respawn", duck_respawn, 1);
      step(); step();
      chk("transition_click_ignored", shots_left, 3);
      left_mouse = 1'b0;
      step();

      // button held for 100 cycles counts once
      left_mouse = 1'b1;
      for (int i = 0; i < 100; i++) step();
      chk("held_one_eval", shots_left, 2);
      left_mouse = 1'b0;
      step();

      // hitbox near the coordinate limit must not wrap
      duck_xpos = 12'd4090; duck_ypos = 12'd4090;
      click(12'd4095, 12'd4095);
      chk("wrap_hit", duck_hit, 1);
      chk("wrap_score", score, 1);

      // asynchronous reset in the middle of HIT
      step();
      #3 rst = 1'b1;
      #1;
      chk("async_rst_hit", duck_hit, 0);
      chk("async_rst_score", score, 0);
      chk("async_rst_count", duck_count, 0);
      chk("async_rst_shots", shots_left, 0);
      chk("async_rst_respawn", duck_respawn, 0);
      chk("async_rst_finished", game_finished, 0);
      game_enable = 1'b0;
      step();
      rst = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
